memaccess_stage: RTL
====================

Name: memaccess_stage

Overview:
Pipeline stage directly upstream of writeback. It registers each instruction from execute and passes it on with a valid/ready handshake. Non-memory instructions pass through after one cycle. LOAD and STORE instructions perform a single blocking data-bus transaction, and loads have their sign or zero extension applied before the result goes to writeback.

Parameters:
DBUS_W, 32, data-bus and register data width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  upstream (execute) instruction valid
ready_o  output  1  stage can accept this cycle
pc_i  input  32  instruction PC
inst_i  input  32  instruction word
r0data_i  input  32  rs1 value
r1data_i  input  32  rs2 value (store data)
result_i  input  32  execute result; effective address for LOAD/STORE
valid_o  output  1  output register holds a valid instruction
ready_i  input  1  downstream accept
pc_o  output  32  registered pc
inst_o  output  32  registered inst
r0data_o  output  32  registered rs1 value
r1data_o  output  32  registered rs2 value
result_o  output  32  execute result, or extended load data
dmem_req_o  output  1  data-bus request, registered
dmem_we_o  output  1  1 = store, 0 = load
dmem_addr_o  output  32  word address, {addr[31:2],2'b00}
dmem_wdata_o  output  32  lane-replicated store data
dmem_be_o  output  4  byte enables (stores); 4'b1111 on loads
dmem_ack_i  input  1  transaction complete; rdata valid this cycle
dmem_rdata_i  input  32  load data

Behaviour:
- Reset (async, rst=1): state=RUN; valid_o=0; dmem_req_o=0; dmem_we_o=0; dmem_be_o=0; all data/address outputs=0. Reset during MEM_WAIT abandons the transaction: req drops immediately and no result is produced.
- Decode: mem_ld = inst_i[6:0]==7'b0000011; mem_st = inst_i[6:0]==7'b0100011; funct3 = inst_i[14:12].
- cke = ~valid_o | ready_i. ready_o = (state==RUN) & cke. Accept = valid_i & ready_o.
- State RUN:
  - Accept of a non-memory instruction: output regs <= inputs; valid_o<=1. Latency is 1 cycle.
  - Accept of a LOAD/STORE: output regs <= inputs; valid_o<=0; dmem_req_o<=1; addr, we, be, wdata driven from the inputs; state<=MEM_WAIT.
  - No accept and ready_i=1: valid_o<=0.
  - No accept and ready_i=0: hold everything.
- State MEM_WAIT:
  - ready_o=0. dmem_req_o and all dmem_* outputs are held stable until ack.
  - On dmem_ack_i=1: dmem_req_o<=0; valid_o<=1; state<=RUN. For a load, result_o<=extended data; for a store, result_o is unchanged.
  - Earliest ack is the cycle after req rises, so minimum memory-instruction latency is 2 cycles. ack while req=0 is ignored.
- Load extension (off = addr[1:0] latched at issue):
  - LB (000): sign-extend byte[off]. LBU (100): zero-extend byte[off].
  - LH (001) / LHU (101): halfword at addr[1]; addr[0] ignored.
  - LW (010) and reserved funct3: full word.
- Store lanes, with rs2 = r1data_i:
  - SB (000): be = 4'b0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH (001): be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW (010) and reserved funct3: be = 4'b1111; wdata = rs2.
- Misalignment is not detected and no trap is raised.
- Back-to-back non-memory instructions with ready_i=1 sustain one instruction per cycle.
- With ready_i=0 the output register stalls and ready_o=0 while valid_o=1.
- dmem_be_o and dmem_we_o return to 0 when req drops.

Test Plan:
1. Reset release, then ADDI (inst 0x00500093, result_i=5) with ready_i=1 -> next cycle valid_o=1, result_o=5; ready_o stays 1.
2. LB, result_i=0x1003, dmem_rdata_i=0x80FF_0000, ack 3 cycles after req -> dmem_addr_o=0x1000; req held 3 cycles; ready_o=0 throughout; then valid_o=1, result_o=0xFFFF_FF80.
3. LHU at 0x2002, rdata=0x8001_1234 -> result_o=0x0000_8001. LW at 0x2000 -> result_o=0x8001_1234.
4. SB at 0x3001, rs2=0x0000_00AB -> we=1, be=4'b0010, wdata=0xABAB_ABAB. SH at 0x3002 -> be=4'b1100. On ack, valid_o=1 and result_o=0x3001.
5. Three ALU instructions back-to-back with ready_i=0 for cycles 2-3 -> first instruction is held on the outputs; ready_o=0 during the stall; no instruction is lost or duplicated; order is preserved.
6. rst pulsed while in MEM_WAIT -> dmem_req_o=0 and valid_o=0 immediately. After release, a pending ack is ignored and the stage accepts new input.

Source files
------------

// File: rtl/memaccess_stage.sv
// memaccess_stage: registers execute output and performs one blocking data-bus access for loads/stores
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_i / ready_o        upstream handshake from execute
//   pc_i, inst_i, r0data_i,
//   r1data_i, result_i       instruction fields; result_i is the effective address for LOAD/STORE
//   valid_o / ready_i        downstream handshake to writeback
//   pc_o, inst_o, r0data_o,
//   r1data_o, result_o       registered fields; result_o carries extended load data after a load
//   dmem_*                   registered data-bus request held stable until dmem_ack_i
module memaccess_stage #(
   parameter int DBUS_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       inst_i,
   input  logic [DBUS_W-1:0] r0data_i,
   input  logic [DBUS_W-1:0] r1data_i,
   input  logic [DBUS_W-1:0] result_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       inst_o,
   output logic [DBUS_W-1:0] r0data_o,
   output logic [DBUS_W-1:0] r1data_o,
   output logic [DBUS_W-1:0] result_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [DBUS_W-1:0] dmem_addr_o,
   output logic [DBUS_W-1:0] dmem_wdata_o,
   output logic [3:0]        dmem_be_o,
   input  logic              dmem_ack_i,
   input  logic [DBUS_W-1:0] dmem_rdata_i
);
   typedef enum logic {RUN, MEM_WAIT} state_t;
   state_t state, state_nx;
   logic              mem_ld, mem_st, mem_op, cke, acc;
   logic [2:0]        f3, lf3;
   logic [3:0]        st_be;
   logic [DBUS_W-1:0] st_wdata, ld_data;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;

   assign mem_ld  = inst_i[6:0] == 7'b0000011;
   assign mem_st  = inst_i[6:0] == 7'b0100011;
   assign mem_op  = mem_ld | mem_st;
   assign f3      = inst_i[14:12];
   assign cke     = ~valid_o | ready_i;
   assign ready_o = (state == RUN) & cke;
   assign acc     = valid_i & ready_o;

   always_comb begin
      st_be    = (f3 == 3'b000) ? 4'b0001 << result_i[1:0] :
                 (f3 == 3'b001) ? (result_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_wdata = (f3 == 3'b000) ? {4{r1data_i[7:0]}} :
                 (f3 == 3'b001) ? {2{r1data_i[15:0]}} : r1data_i;
   end

   // While waiting, the latched instruction and address (inst_o, result_o) select the load lane.
   always_comb begin
      lf3     = inst_o[14:12];
      ld_b    = dmem_rdata_i[{result_o[1:0], 3'b000} +: 8];
      ld_h    = result_o[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      ld_data = (lf3 == 3'b000) ? {{24{ld_b[7]}}, ld_b} :
                (lf3 == 3'b100) ? {24'b0, ld_b} :
                (lf3 == 3'b001) ? {{16{ld_h[15]}}, ld_h} :
                (lf3 == 3'b101) ? {16'b0, ld_h} : dmem_rdata_i;
   end

   always_comb begin
      state_nx = state;
      state_nx = (state == RUN) ? ((acc & mem_op) ? MEM_WAIT : RUN) :
                 (dmem_ack_i ? RUN : MEM_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o      <= 1'b0;
         pc_o         <= '0;
         inst_o       <= '0;
         r0data_o     <= '0;
         r1data_o     <= '0;
         result_o     <= '0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         dmem_be_o    <= 4'b0;
      end else if (state == RUN) begin
         if (acc) begin
            pc_o     <= pc_i;
            inst_o   <= inst_i;
            r0data_o <= r0data_i;
            r1data_o <= r1data_i;
            result_o <= result_i;
            valid_o  <= ~mem_op;
            if (mem_op) begin
               dmem_req_o   <= 1'b1;
               dmem_we_o    <= mem_st;
               dmem_addr_o  <= {result_i[31:2], 2'b00};
               dmem_wdata_o <= st_wdata;
               dmem_be_o    <= mem_st ? st_be : 4'b1111;
            end
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
      end else if (dmem_ack_i) begin
         dmem_req_o <= 1'b0;
         dmem_we_o  <= 1'b0;
         dmem_be_o  <= 4'b0;
         valid_o    <= 1'b1;
         if (!dmem_we_o) result_o <= ld_data;
      end
   end
endmodule
